// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs decoded fields and a signed immediate into a
// 32-bit word, range-checks the immediate, and queues {instr, addr} pairs in a small FIFO.
module legv8_instr_encoder #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [10:0]       opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [5:0]        shamt,
    input  logic [63:0]       imm,
    input  logic              clr_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic              err_sticky,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_CB = 3'd4;
    localparam logic [2:0] FMT_IW = 3'd5;

    logic [31:0]       encWord;
    logic              immLegal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              reject;

    logic [31:0]       instrMem [DEPTH];
    logic [ADDR_W-1:0] addrMem  [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addrCnt;

    // Signed fields fit when every bit above the field's sign bit equals it;
    // unsigned fields fit when everything above the field is zero.
    always_comb begin
        encWord  = '0;
        immLegal = 1'b0;
        case (fmt)
            FMT_R: begin
                encWord  = {opcode, rm, shamt, rn, rd};
                immLegal = 1'b1;
            end
            FMT_I: begin
                encWord  = {opcode[10:1], imm[11:0], rn, rd};
                immLegal = ~|imm[63:12];
            end
            FMT_D: begin
                encWord  = {opcode, imm[8:0], 2'b00, rn, rd};
                immLegal = (&imm[63:8]) | (~|imm[63:8]);
            end
            FMT_B: begin
                encWord  = {opcode[10:5], imm[25:0]};
                immLegal = (&imm[63:25]) | (~|imm[63:25]);
            end
            FMT_CB: begin
                encWord  = {opcode[10:3], imm[18:0], rd};
                immLegal = (&imm[63:18]) | (~|imm[63:18]);
            end
            FMT_IW: begin
                encWord  = {opcode[10:2], shamt[1:0], imm[15:0], rd};
                immLegal = ~|imm[63:16];
            end
            default: begin
                encWord  = '0;
                immLegal = 1'b0;
            end
        endcase
    end

    assign out_valid = (count != '0);
    assign in_ready  = rst_n && ((count < CNT_W'(DEPTH)) || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign push      = accept && immLegal;
    assign reject    = accept && !immLegal;
    assign pop       = out_valid && out_ready;

    assign instr = out_valid ? instrMem[headPtr] : '0;
    assign addr  = out_valid ? addrMem[headPtr]  : BASE_ADDR;

    // Storage needs no reset: the occupancy count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[tailPtr] <= encWord;
            addrMem[tailPtr]  <= addrCnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            addrCnt <= BASE_ADDR;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
                addrCnt <= addrCnt + ADDR_W'(4);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear in the same cycle as a rejection wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (reject) begin
            err_sticky <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
